// File: rtl/spi_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_wrapper_if
// Description : SPI slave-side signal bundle (sck, sdi, cs) between the MCU
//               (master modport) and the coefficient receiver (slave modport).
//               sck : SPI clock, free-running, asynchronous to clk
//               sdi : serial data, MSB first, sampled on sck rise
//               cs  : chip select, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_wrapper_if;
  logic sck;
  logic sdi;
  logic cs;

  modport master (output sck, output sdi, output cs);
  modport slave  (input  sck, input  sdi, input  cs);
endinterface
`default_nettype wire

// File: rtl/spi_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : spi_wrapper
// Description : SPI slave that receives 336-bit frames and extracts 15 signed
//               16-bit biquad coefficients (low/mid/high x b0,b1,b2,a1,a2).
//               All SPI lines are oversampled in the clk domain; a frame is
//               found by sliding-window search for the sync word in the top
//               16 bits of the shift register.
// Ports       : clk          system clock
//               reset        asynchronous, active-low reset
//               spi          SPI lines (slave modport: sck, sdi, cs)
//               low_*/mid_*/high_*  registered coefficients, held until the
//                            next good frame
//               valid_out    high while outputs hold a set captured in the
//                            current CS-low session
// Revision    : 1.0 - initial release
// ============================================================================
module spi_wrapper #(
  parameter int          FRAME_BITS  = 336,
  parameter logic [15:0] SYNC_WORD   = 16'hAA55,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  spi_wrapper_if.slave       spi,
  output logic signed [15:0] low_b0,
  output logic signed [15:0] low_b1,
  output logic signed [15:0] low_b2,
  output logic signed [15:0] low_a1,
  output logic signed [15:0] low_a2,
  output logic signed [15:0] mid_b0,
  output logic signed [15:0] mid_b1,
  output logic signed [15:0] mid_b2,
  output logic signed [15:0] mid_a1,
  output logic signed [15:0] mid_a2,
  output logic signed [15:0] high_b0,
  output logic signed [15:0] high_b1,
  output logic signed [15:0] high_b2,
  output logic signed [15:0] high_a1,
  output logic signed [15:0] high_a2,
  output logic               valid_out
);

  localparam int          c_NUM_COEF = 15;
  localparam int          c_COEF_MSB = c_NUM_COEF * 16 - 1;
  localparam logic [15:0] c_UNITY    = 16'h4000;

  // Receiver states: IDLE while cs is high, HUNT while searching for the
  // sync word, LOCK once a frame has been captured in this CS session.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HUNT = 2'd1;
  localparam logic [1:0] c_ST_LOCK = 2'd2;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;

  logic [FRAME_BITS-1:0]  r_shift;
  logic                   r_shifted;   // a shift happened on the previous clk
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;

  logic [15:0]            r_coef [c_NUM_COEF];
  logic                   r_valid;

  logic w_sck_s;
  logic w_sdi_s;
  logic w_cs_high;
  logic w_sck_rise;
  logic w_match;
  logic w_clear;
  logic w_shift_en;
  logic w_load;

  // --------------------------------------------------------------------------
  // Input synchronizers. cs resets high so the receiver starts deselected.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '1;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi.sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi.sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs};
      r_sck_d    <= w_sck_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_high  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;

  // Only evaluated on the clk right after a shift, so a stale window can
  // never re-trigger a capture.
  assign w_match = r_shifted && (r_shift[FRAME_BITS-1 -: 16] == SYNC_WORD);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (!w_cs_high) w_state_nxt = c_ST_HUNT;
      c_ST_HUNT: begin
        if (w_cs_high)    w_state_nxt = c_ST_IDLE;
        else if (w_match) w_state_nxt = c_ST_LOCK;
      end
      c_ST_LOCK: if (w_cs_high) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Shifting is allowed in IDLE as well so that an sck rise
  // arriving in the same clk that cs is first seen low is not lost.
  // --------------------------------------------------------------------------
  always_comb begin
    w_clear    = w_cs_high;
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    if (!w_cs_high && (r_state != c_ST_LOCK)) begin
      w_shift_en = w_sck_rise;
      w_load     = (r_state == c_ST_HUNT) && w_match;
    end
  end

  // --------------------------------------------------------------------------
  // Frame shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_shifted <= 1'b0;
    end else if (w_clear) begin
      r_shift   <= '0;
      r_shifted <= 1'b0;
    end else begin
      r_shifted <= w_shift_en;
      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_s};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient bank and valid flag. Coefficient k sits at frame bits
  // [239-16k -: 16]; every fifth entry is a b0 and resets to unity gain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      for (int k = 0; k < c_NUM_COEF; k++) begin
        r_coef[k] <= ((k % 5) == 0) ? c_UNITY : 16'h0000;
      end
    end else if (w_clear) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      for (int k = 0; k < c_NUM_COEF; k++) begin
        r_coef[k] <= r_shift[c_COEF_MSB - 16*k -: 16];
      end
    end
  end

  assign low_b0    = r_coef[0];
  assign low_b1    = r_coef[1];
  assign low_b2    = r_coef[2];
  assign low_a1    = r_coef[3];
  assign low_a2    = r_coef[4];
  assign mid_b0    = r_coef[5];
  assign mid_b1    = r_coef[6];
  assign mid_b2    = r_coef[7];
  assign mid_a1    = r_coef[8];
  assign mid_a2    = r_coef[9];
  assign high_b0   = r_coef[10];
  assign high_b1   = r_coef[11];
  assign high_b2   = r_coef[12];
  assign high_a1   = r_coef[13];
  assign high_a2   = r_coef[14];
  assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_wrapper
// Description : Self-checking bench for spi_wrapper. An SPI master drives
//               directed and random frames; a reference model holds the
//               expected coefficient set and valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_wrapper;

  localparam int HALF        = 40;   // sck half period in ns
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic reset;

  logic [15:0] dut_c [15];
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_c [15];
  logic        exp_valid;
  logic [15:0] nxt   [15];   // coefficient words of the frame being built

  logic [15:0] edge_vals [6] = '{16'h8000, 16'hFFFF, 16'h7FFF,
                                 16'hC000, 16'h0001, 16'hFFFE};
  logic [15:0] pat_vals [15] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111,
                                 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
                                 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB};
  logic [15:0] cafe_vals [15] = '{16'hCAFE, 16'hBABE, 16'hDEAD, 16'hBEEF, 16'hFEED,
                                  16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                  16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA};

  spi_wrapper_if spi ();

  spi_wrapper #(
    .FRAME_BITS  (336),
    .SYNC_WORD   (16'hAA55),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi),
    .low_b0    (dut_c[0]),
    .low_b1    (dut_c[1]),
    .low_b2    (dut_c[2]),
    .low_a1    (dut_c[3]),
    .low_a2    (dut_c[4]),
    .mid_b0    (dut_c[5]),
    .mid_b1    (dut_c[6]),
    .mid_b2    (dut_c[7]),
    .mid_a1    (dut_c[8]),
    .mid_a2    (dut_c[9]),
    .high_b0   (dut_c[10]),
    .high_b1   (dut_c[11]),
    .high_b2   (dut_c[12]),
    .high_a1   (dut_c[13]),
    .high_a2   (dut_c[14]),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("%s_c%0d", tag, k), 32'(dut_c[k]), 32'(exp_c[k]));
    end
    chk($sformatf("%s_valid", tag), 32'(valid_out), 32'(exp_valid));
  endtask

  // Frame = sync word, five ADC words, then the 15 coefficients in order.
  function automatic logic [335:0] build(input logic [15:0] sy, input logic [79:0] adc);
    logic [239:0] c;
    for (int k = 0; k < 15; k++) c[239 - 16*k -: 16] = nxt[k];
    return {sy, adc, c};
  endfunction

  task automatic send_bit(input logic b);
    spi.sck = 1'b0;
    spi.sdi = b;
    #HALF;
    spi.sck = 1'b1;
    #HALF;
  endtask

  task automatic cs_begin();
    spi.cs = 1'b0;
    #(2*HALF);
  endtask

  // Raise cs with sck still running for a few cycles; the model drops valid.
  task automatic cs_end(input string tag);
    spi.sck = 1'b0;
    #HALF;
    spi.cs = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    exp_valid = 1'b0;
    check_all(tag);
  endtask

  // Send stray zero bits, then the frame, and check capture latency on the
  // final bit. A frame with the right sync word updates the model.
  task automatic send_frame(input string tag, input logic [335:0] f, input int stray);
    logic good;
    good = (f[335:320] == 16'hAA55);
    for (int i = 0; i < stray; i++) send_bit(1'b0);
    for (int i = 335; i > 0; i--) send_bit(f[i]);
    spi.sck = 1'b0;
    spi.sdi = f[0];
    #HALF;
    spi.sck = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_early"}, 32'(valid_out), 32'(0));
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    chk({tag, "_valid_latency"}, 32'(valid_out), 32'(good));
    @(posedge clk); #2;
    if (good) begin
      for (int k = 0; k < 15; k++) exp_c[k] = nxt[k];
      exp_valid = 1'b1;
    end
    check_all(tag);
  endtask

  initial begin
    logic [15:0] sy;
    reset   = 1'b0;
    spi.cs  = 1'b1;
    spi.sck = 1'b0;
    spi.sdi = 1'b0;
    for (int k = 0; k < 15; k++) exp_c[k] = ((k % 5) == 0) ? 16'h4000 : 16'h0000;
    exp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all("reset");

    // Unity-gain frame
    for (int k = 0; k < 15; k++) nxt[k] = ((k % 5) == 0) ? 16'h4000 : 16'h0000;
    cs_begin();
    send_frame("unity", build(16'hAA55, 80'h0), 0);
    cs_end("unity_cs_hi");

    // Distinct pattern, with signed interpretation of 0x9ABC
    for (int k = 0; k < 15; k++) nxt[k] = pat_vals[k];
    cs_begin();
    send_frame("pattern", build(16'hAA55, 80'h0), 3);
    chk("signed_9abc", 32'($signed(dut_c[2])), 32'(-25924));
    cs_end("pattern_cs_hi");

    // Signed edge values, then sck keeps running while locked
    for (int k = 0; k < 15; k++) nxt[k] = edge_vals[k % 6];
    cs_begin();
    send_frame("edges", build(16'hAA55, {32'($urandom), 32'($urandom), 16'($urandom)}), 0);
    for (int i = 0; i < 120; i++) send_bit(1'($urandom));
    check_all("edges_locked");
    cs_end("edges_cs_hi");

    // Aborted frame: 100 random bits then cs high
    cs_begin();
    for (int i = 0; i < 100; i++) send_bit(1'($urandom));
    cs_end("abort");

    for (int k = 0; k < 15; k++) nxt[k] = cafe_vals[k];
    cs_begin();
    send_frame("cafe", build(16'hAA55, 80'h0), 0);
    cs_end("cafe_cs_hi");

    // Back-to-back frames
    for (int k = 0; k < 15; k++) nxt[k] = 16'(k + 1);
    cs_begin();
    send_frame("b2b_1", build(16'hAA55, 80'h0), 0);
    cs_end("b2b_1_cs_hi");
    for (int k = 0; k < 15; k++) nxt[k] = 16'hF001 + 16'(k);
    cs_begin();
    send_frame("b2b_2", build(16'hAA55, 80'h0), 0);
    cs_end("b2b_2_cs_hi");

    // Wrong sync word: nothing captured
    sy = 16'($urandom);
    if (sy == 16'hAA55) sy = 16'h55AA;
    for (int k = 0; k < 15; k++) nxt[k] = 16'($urandom);
    cs_begin();
    send_frame("badsync", build(sy, {32'($urandom), 32'($urandom), 16'($urandom)}), 0);
    cs_end("badsync_cs_hi");

    // Random frames with random stray leading sck rises
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 15; k++) nxt[k] = 16'($urandom);
      cs_begin();
      send_frame($sformatf("rand%0d", n),
                 build(16'hAA55, {32'($urandom), 32'($urandom), 16'($urandom)}),
                 int'($urandom_range(0, 20)));
      cs_end($sformatf("rand%0d_cs_hi", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
